// File: rtl/alu_div_seq_if.sv
// ALU operand/control/result bundle between alu_div_seq (master) and the
// shared execute-stage ALU (slave).
interface alu_div_seq_if;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic        alu_Cin;
    logic [2:0]  alu_Op;
    logic        alu_invA;
    logic        alu_invB;
    logic        alu_sign;
    logic [15:0] alu_Out;
    logic        alu_Cout;

    modport master (
        output alu_A, alu_B, alu_Cin, alu_Op, alu_invA, alu_invB, alu_sign,
        input  alu_Out, alu_Cout
    );

    modport slave (
        input  alu_A, alu_B, alu_Cin, alu_Op, alu_invA, alu_invB, alu_sign,
        output alu_Out, alu_Cout
    );
endinterface

// File: rtl/alu_div_seq.sv
// Restoring 16-bit divider, one quotient bit per cycle, using an external ALU.
// Define SIGNED_DIV_EN to honour signed_op (adds NEG_A/NEG_B/FIX_Q/FIX_R).
module alu_div_seq (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   dividend,
    input  logic [15:0]   divisor,
    input  logic          signed_op,
    output logic          busy,
    output logic          done,
    output logic [15:0]   quotient,
    output logic [15:0]   remainder,
    output logic          div_by_zero,
    alu_div_seq_if.master alu
);

`ifdef SIGNED_DIV_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEG_A = 3'd1,
        NEG_B = 3'd2,
        ITER  = 3'd3,
        FIX_Q = 3'd4,
        FIX_R = 3'd5,
        DONE  = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ITER = 3'd3,
        DONE = 3'd6
    } state_t;
`endif

    state_t      state_r, state_nxt_s;
    logic [15:0] r_r, r_nxt_s;
    logic [15:0] q_r, q_nxt_s;
    logic [15:0] d_r, d_nxt_s;
    logic [3:0]  count_r, count_nxt_s;
    logic        dz_r, dz_nxt_s;
    logic [15:0] shifted_s;
    logic        busy_r, done_r, dbz_out_r;
    logic [15:0] quotient_r, remainder_r;

`ifdef SIGNED_DIV_EN
    logic        signed_run_r, signed_run_nxt_s;
    logic        neg_r_r, neg_r_nxt_s;
    logic        neg_q_r, neg_q_nxt_s;
`else
    logic        unused_signed_s;
    assign unused_signed_s = signed_op;
`endif

    // Partial remainder shifted left with the next dividend bit entering at the bottom.
    assign shifted_s = {r_r[14:0], q_r[15]};

    // ALU drive decoded from registered state only, keeping the ALU path acyclic.
    always_comb begin
        alu.alu_A    = 16'h0000;
        alu.alu_B    = 16'h0000;
        alu.alu_Cin  = 1'b0;
        alu.alu_invA = 1'b0;
        alu.alu_invB = 1'b0;
        alu.alu_sign = 1'b0;
        alu.alu_Op   = 3'b100;
        case (state_r)
            ITER: begin
                alu.alu_A    = shifted_s;
                alu.alu_B    = d_r;
                alu.alu_invB = 1'b1;
                alu.alu_Cin  = 1'b1;
            end
`ifdef SIGNED_DIV_EN
            NEG_A, FIX_Q: begin
                alu.alu_A    = q_r;
                alu.alu_invA = 1'b1;
                alu.alu_Cin  = 1'b1;
                alu.alu_sign = 1'b1;
            end
            NEG_B: begin
                alu.alu_A    = d_r;
                alu.alu_invA = 1'b1;
                alu.alu_Cin  = 1'b1;
                alu.alu_sign = 1'b1;
            end
            FIX_R: begin
                alu.alu_A    = r_r;
                alu.alu_invA = 1'b1;
                alu.alu_Cin  = 1'b1;
                alu.alu_sign = 1'b1;
            end
`endif
            default: begin
                alu.alu_A = 16'h0000;
            end
        endcase
    end

    // Next-state and datapath update, consuming the ALU result in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        r_nxt_s     = r_r;
        q_nxt_s     = q_r;
        d_nxt_s     = d_r;
        count_nxt_s = count_r;
        dz_nxt_s    = dz_r;
`ifdef SIGNED_DIV_EN
        signed_run_nxt_s = signed_run_r;
        neg_r_nxt_s      = neg_r_r;
        neg_q_nxt_s      = neg_q_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    d_nxt_s     = divisor;
                    count_nxt_s = 4'd0;
`ifdef SIGNED_DIV_EN
                    signed_run_nxt_s = signed_op;
                    neg_r_nxt_s      = signed_op & dividend[15];
                    neg_q_nxt_s      = signed_op & (dividend[15] ^ divisor[15]);
`endif
                    if (divisor == 16'h0000) begin
                        q_nxt_s     = 16'hFFFF;
                        r_nxt_s     = dividend;
                        dz_nxt_s    = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        q_nxt_s  = dividend;
                        r_nxt_s  = 16'h0000;
                        dz_nxt_s = 1'b0;
`ifdef SIGNED_DIV_EN
                        if (signed_op) begin
                            state_nxt_s = NEG_A;
                        end else begin
                            state_nxt_s = ITER;
                        end
`else
                        state_nxt_s = ITER;
`endif
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
`ifdef SIGNED_DIV_EN
            NEG_A: begin
                if (q_r[15]) begin
                    q_nxt_s = alu.alu_Out;
                end else begin
                    q_nxt_s = q_r;
                end
                state_nxt_s = NEG_B;
            end
            NEG_B: begin
                if (d_r[15]) begin
                    d_nxt_s = alu.alu_Out;
                end else begin
                    d_nxt_s = d_r;
                end
                state_nxt_s = ITER;
            end
`endif
            ITER: begin
                // Bit shifted out of R means the 17-bit value certainly exceeds D.
                if (r_r[15] | alu.alu_Cout) begin
                    r_nxt_s = alu.alu_Out;
                    q_nxt_s = {q_r[14:0], 1'b1};
                end else begin
                    r_nxt_s = shifted_s;
                    q_nxt_s = {q_r[14:0], 1'b0};
                end
                count_nxt_s = count_r + 4'd1;
                if (count_r == 4'd15) begin
`ifdef SIGNED_DIV_EN
                    if (signed_run_r) begin
                        state_nxt_s = FIX_Q;
                    end else begin
                        state_nxt_s = DONE;
                    end
`else
                    state_nxt_s = DONE;
`endif
                end else begin
                    state_nxt_s = ITER;
                end
            end
`ifdef SIGNED_DIV_EN
            FIX_Q: begin
                if (neg_q_r) begin
                    q_nxt_s = alu.alu_Out;
                end else begin
                    q_nxt_s = q_r;
                end
                state_nxt_s = FIX_R;
            end
            FIX_R: begin
                if (neg_r_r) begin
                    r_nxt_s = alu.alu_Out;
                end else begin
                    r_nxt_s = r_r;
                end
                state_nxt_s = DONE;
            end
`endif
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            r_r     <= 16'h0000;
            q_r     <= 16'h0000;
            d_r     <= 16'h0000;
            count_r <= 4'd0;
            dz_r    <= 1'b0;
`ifdef SIGNED_DIV_EN
            signed_run_r <= 1'b0;
            neg_r_r      <= 1'b0;
            neg_q_r      <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            r_r     <= r_nxt_s;
            q_r     <= q_nxt_s;
            d_r     <= d_nxt_s;
            count_r <= count_nxt_s;
            dz_r    <= dz_nxt_s;
`ifdef SIGNED_DIV_EN
            signed_run_r <= signed_run_nxt_s;
            neg_r_r      <= neg_r_nxt_s;
            neg_q_r      <= neg_q_nxt_s;
`endif
        end
    end

    // Registered status and result outputs; results load on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= 16'h0000;
            remainder_r <= 16'h0000;
            dbz_out_r   <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= (state_nxt_s == DONE);
            if (state_nxt_s == DONE) begin
                quotient_r  <= q_nxt_s;
                remainder_r <= r_nxt_s;
                dbz_out_r   <= dz_nxt_s;
            end else begin
                quotient_r  <= quotient_r;
                remainder_r <= remainder_r;
                dbz_out_r   <= dbz_out_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_out_r;

endmodule
